systolic_test_array: RTL and testbench

Output-stationary 3×3 systolic matrix-multiply core for accelerator bring-up.
- A row operands enter on the west edge; B column operands enter on the north edge.
- A controller skews the reads and gates accumulation.
- Each processing element (PE) keeps one C element.
- Sits between the operand memories (driven by the read enables) and the result readout (C bus).

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/systolic_test_array_if.sv | 26 ++
 rtl/systolic_pe.sv | 32 +++
 rtl/systolic_test_array.sv | 108 ++++++++++
 tb/tb_systolic_test_array.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared defaults, controller state encoding and counter sizing for the 3x3 systolic core.
package systolic_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_N          = 3;
    localparam int unsigned DEF_M          = 3;
    localparam int unsigned DEF_K          = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned n, input int unsigned m,
                                              input int unsigned k);
        return $clog2(n + m + k);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEF_N, DEF_M, DEF_K);

endpackage

// File: rtl/systolic_test_array_if.sv
// Operand-memory / result-readout bus of the systolic core; master is the core side.
interface systolic_test_array_if #(
    parameter int unsigned DATA_WIDTH = systolic_pkg::DEF_DATA_WIDTH,
    parameter int unsigned N          = systolic_pkg::DEF_N,
    parameter int unsigned M          = systolic_pkg::DEF_M
);
    logic                          finished;
    logic [N*DATA_WIDTH-1:0]       A_in;
    logic [M*DATA_WIDTH-1:0]       B_in;
    logic [N-1:0]                  A_read_en;
    logic [M-1:0]                  B_read_en;
    logic                          load_out;
    logic [N*M*DATA_WIDTH-1:0]     C_out;
    logic [N*DATA_WIDTH-1:0]       A_east;
    logic [M*DATA_WIDTH-1:0]       B_south;

    modport master (
        input  finished, A_in, B_in,
        output A_read_en, B_read_en, load_out, C_out, A_east, B_south
    );

    modport slave (
        output finished, A_in, B_in,
        input  A_read_en, B_read_en, load_out, C_out, A_east, B_south
    );
endinterface

// File: rtl/systolic_pe.sv
// Output-stationary processing element: forwards A east and B south, accumulates A*B.
module systolic_pe #(
    parameter int unsigned DATA_WIDTH = systolic_pkg::DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] A_in,
    input  logic [DATA_WIDTH-1:0] B_in,
    output logic [DATA_WIDTH-1:0] A_out,
    output logic [DATA_WIDTH-1:0] B_out,
    output logic [DATA_WIDTH-1:0] C_out
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            A_out <= '0;
            B_out <= '0;
            C_out <= '0;
        end else begin
            A_out <= A_in;
            B_out <= B_in;
            // Product and sum wrap modulo 2^DATA_WIDTH.
            if (clr)
                C_out <= '0;
            else if (load)
                C_out <= C_out + A_in * B_in;
        end
    end

endmodule

// File: rtl/systolic_test_array.sv
// N x M output-stationary systolic matmul core with skewed-read controller.
// Optional SYSTOLIC_TRACE_EN: simulation-only start message.
module systolic_test_array #(
    parameter int unsigned DATA_WIDTH = systolic_pkg::DEF_DATA_WIDTH,
    parameter int unsigned N          = systolic_pkg::DEF_N,
    parameter int unsigned M          = systolic_pkg::DEF_M,
    parameter int unsigned K          = systolic_pkg::DEF_K
) (
    input  logic                   clk,
    input  logic                   rst,
    systolic_test_array_if.master  bus
);
    import systolic_pkg::*;

    localparam int unsigned TW     = cnt_width(N, M, K);
    localparam int unsigned T_LAST = N + M + K - 3;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [31:0]     t_ext;
    logic            clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            IDLE: begin
                state_d = RUN;
                t_d     = '0;
            end
            RUN: begin
                if (t_q == TW'(T_LAST))
                    state_d = DONE;
                else
                    t_d = t_q + 1'b1;
            end
            DONE: begin
                if (bus.finished)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign t_ext        = 32'(t_q);
    assign bus.load_out = (state_q == RUN);
    assign clr          = (state_q == IDLE);

    // Row/column r is read during t in [r, r+K-1], producing the diagonal skew.
    always_comb begin
        bus.A_read_en = '0;
        bus.B_read_en = '0;
        for (int unsigned i = 0; i < N; i++)
            bus.A_read_en[i] = bus.load_out && (t_ext >= i) && (t_ext <= i + K - 1);
        for (int unsigned j = 0; j < M; j++)
            bus.B_read_en[j] = bus.load_out && (t_ext >= j) && (t_ext <= j + K - 1);
    end

    logic [DATA_WIDTH-1:0] a_h [N][M+1];
    logic [DATA_WIDTH-1:0] b_v [N+1][M];

    for (genvar i = 0; i < N; i++) begin : g_west
        assign a_h[i][0] = bus.A_read_en[i] ? bus.A_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign bus.A_east[i*DATA_WIDTH +: DATA_WIDTH] = a_h[i][M];
    end

    for (genvar j = 0; j < M; j++) begin : g_north
        assign b_v[0][j] = bus.B_read_en[j] ? bus.B_in[j*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign bus.B_south[j*DATA_WIDTH +: DATA_WIDTH] = b_v[N][j];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < M; j++) begin : g_col
            systolic_pe #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .load  (bus.load_out),
                .A_in  (a_h[i][j]),
                .B_in  (b_v[i][j]),
                .A_out (a_h[i][j+1]),
                .B_out (b_v[i+1][j]),
                .C_out (bus.C_out[(M*i+j)*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    end

`ifdef SYSTOLIC_TRACE_EN
    initial begin
        $display("systolic_test_array: trace enabled, N=%0d M=%0d K=%0d DW=%0d",
                 N, M, K, DATA_WIDTH);
    end
`else
`endif

endmodule

// File: tb/tb_systolic_test_array.sv
// Directed, table-driven bench for systolic_test_array with a read-enable driven operand memory.
module tb_systolic_test_array;

    typedef logic [0:2][0:2][31:0] mat_t;
    typedef struct packed {
        mat_t a;
        mat_t b;
        mat_t c;
    } vec_t;

    logic clk;
    logic rst;

    systolic_test_array_if #(.DATA_WIDTH(32), .N(3), .M(3)) bus ();

    systolic_test_array #(
        .DATA_WIDTH (32),
        .N          (3),
        .M          (3),
        .K          (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    mat_t cur_a, cur_b;
    int unsigned pa [3];
    int unsigned pb [3];

    // Operand memories: one read pointer per row/column, advanced by each enabled read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                pa[i] <= 0;
                pb[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (bus.A_read_en[i]) pa[i] <= (pa[i] == 2) ? 0 : pa[i] + 1;
                if (bus.B_read_en[i]) pb[i] <= (pb[i] == 2) ? 0 : pb[i] + 1;
            end
        end
    end

    // Garbage is driven whenever an enable is low so the edge mux is always exercised.
    always_comb begin
        bus.A_in = '0;
        bus.B_in = '0;
        for (int i = 0; i < 3; i++) begin
            bus.A_in[i*32 +: 32] = bus.A_read_en[i] ? cur_a[i][pa[i]] : (32'hBAD0_0A00 | 32'(i));
            bus.B_in[i*32 +: 32] = bus.B_read_en[i] ? cur_b[pb[i]][i] : (32'hBAD0_0B00 | 32'(i));
        end
    end

    function automatic mat_t m3(input logic [31:0] x0, x1, x2, x3, x4, x5, x6, x7, x8);
        return {x0, x1, x2, x3, x4, x5, x6, x7, x8};
    endfunction

    function automatic logic [287:0] pack_c(input mat_t c);
        logic [287:0] r;
        r = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                r[(3*i+j)*32 +: 32] = c[i][j];
        return r;
    endfunction

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs from the current negedge until DONE (stop_at < 0) or until RUN cycle stop_at.
    task automatic run_phase(input int stop_at, input string tag);
        int  t;
        logic [2:0] exp_en;
        t = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.load_out) begin
                if (t == 0) chk({tag, " C zero at t0"}, bus.C_out, '0);
                for (int r = 0; r < 3; r++) exp_en[r] = (t >= r) && (t <= r + 2);
                chk($sformatf("%s A_read_en t%0d", tag, t), 288'(bus.A_read_en), 288'(exp_en));
                chk($sformatf("%s B_read_en t%0d", tag, t), 288'(bus.B_read_en), 288'(exp_en));
                if (t == stop_at) return;
                t++;
            end else if (t > 0) begin
                chk({tag, " load_out cycles"}, 288'(t), 288'(7));
                return;
            end
        end
        chk({tag, " timeout waiting for DONE"}, 288'(0), 288'(1));
    endtask

    task automatic check_done(input vec_t v, input string tag);
        chk({tag, " C"}, bus.C_out, pack_c(v.c));
        chk({tag, " A_east"}, 288'(bus.A_east), 288'({v.a[2][2], 64'h0}));
        chk({tag, " B_south"}, 288'(bus.B_south), 288'({v.b[2][2], 64'h0}));
    endtask

    task automatic start_run(input vec_t v, input string tag);
        cur_a = v.a;
        cur_b = v.b;
        bus.finished = 1'b1;
        @(negedge clk);
        chk({tag, " load_out in IDLE"}, 288'(bus.load_out), 288'(0));
        bus.finished = 1'b0;
    endtask

    vec_t vecs [5];

    initial begin
        n_vec = 0;
        n_err = 0;

        vecs[0].a = m3(1, 1, 1, 1, 1, 1, 1, 1, 1);
        vecs[0].b = m3(1, 1, 1, 1, 1, 1, 1, 1, 1);
        vecs[0].c = m3(3, 3, 3, 3, 3, 3, 3, 3, 3);
        vecs[1].a = m3(1, 0, 0, 0, 1, 0, 0, 0, 1);
        vecs[1].b = m3(1, 2, 3, 4, 5, 6, 7, 8, 9);
        vecs[1].c = m3(1, 2, 3, 4, 5, 6, 7, 8, 9);
        vecs[2].a = m3(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2].b = m3(2, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2].c = m3(32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3].a = m3(1, 2, 3, 4, 5, 6, 7, 8, 9);
        vecs[3].b = m3(1, 0, 0, 0, 1, 0, 0, 0, 1);
        vecs[3].c = m3(1, 2, 3, 4, 5, 6, 7, 8, 9);
        vecs[4].a = m3(1, 2, 3, 4, 5, 6, 7, 8, 9);
        vecs[4].b = m3(9, 8, 7, 6, 5, 4, 3, 2, 1);
        vecs[4].c = m3(30, 24, 18, 84, 69, 54, 138, 114, 90);

        rst = 1'b0;
        bus.finished = 1'b0;
        cur_a = vecs[0].a;
        cur_b = vecs[0].b;
        repeat (2) @(negedge clk);
        chk("reset load_out", 288'(bus.load_out), 288'(0));
        chk("reset A_read_en", 288'(bus.A_read_en), 288'(0));
        chk("reset B_read_en", 288'(bus.B_read_en), 288'(0));
        chk("reset C_out", bus.C_out, '0);
        chk("reset A_east", 288'(bus.A_east), 288'(0));
        chk("reset B_south", 288'(bus.B_south), 288'(0));
        rst = 1'b1;

        for (int v = 0; v < 5; v++) begin
            if (v > 0) start_run(vecs[v], $sformatf("v%0d", v));
            run_phase(-1, $sformatf("v%0d", v));
            check_done(vecs[v], $sformatf("v%0d", v));
            if (v == 0) begin
                bus.finished = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk($sformatf("hold C cycle %0d", c), bus.C_out, pack_c(vecs[0].c));
                    chk($sformatf("hold load_out cycle %0d", c), 288'(bus.load_out), 288'(0));
                end
            end
        end

        // Asynchronous reset at RUN cycle 3, then a fresh run with different operands.
        start_run(vecs[4], "mid-rst");
        run_phase(3, "mid-rst");
        rst = 1'b0;
        #1;
        chk("mid-rst load_out", 288'(bus.load_out), 288'(0));
        chk("mid-rst read_en", 288'({bus.A_read_en, bus.B_read_en}), 288'(0));
        chk("mid-rst C_out", bus.C_out, '0);
        chk("mid-rst A_east", 288'(bus.A_east), 288'(0));
        chk("mid-rst B_south", 288'(bus.B_south), 288'(0));
        cur_a = vecs[1].a;
        cur_b = vecs[1].b;
        @(negedge clk);
        rst = 1'b1;
        run_phase(-1, "rerun");
        check_done(vecs[1], "rerun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
